dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response, range 0..15.
REQ-002 Parameter DEPTH, default 1024: number of 32-bit words in the backing array.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset; synchronous, active-low (0 = reset).
REQ-005 req_valid  input  1  MA-stage request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address; word-aligned.
REQ-009 req_wdata  input  32  store data (the MDR value).
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  initiator accepts the response this cycle.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access was misaligned or out of range.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-016 On acceptance, the block SHALL register req_we, req_addr and req_wdata; later changes on the req_* inputs SHALL have no effect.
REQ-017 On acceptance with WAIT_CYCLES>0, the FSM SHALL go IDLE->WAIT and load the down-counter with WAIT_CYCLES-1.
REQ-018 In WAIT, the FSM SHALL decrement the counter and go to RESP on the edge where the counter equals 0.
REQ-019 On acceptance with WAIT_CYCLES=0, the FSM SHALL go IDLE->RESP directly.
REQ-020 Latency: for a request accepted at edge T, rsp_valid SHALL first be 1 in the cycle after edge T+WAIT_CYCLES.
REQ-021 On entry to RESP, a store SHALL write the array and a load SHALL capture array data into rsp_rdata.
REQ-022 rsp_err SHALL be 1 when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH.
REQ-023 On an error, the block SHALL suppress the array write and drive rsp_rdata to 0.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-025 On the edge where rsp_ready=1, the FSM SHALL go RESP->IDLE; req_ready rises in the next cycle.
REQ-026 Outside RESP, rsp_valid SHALL be 0, and rsp_rdata and rsp_err SHALL be 0.
REQ-027 rsp_ready asserted outside RESP SHALL be ignored.
REQ-028 req_valid asserted outside IDLE SHALL be ignored; at most one transaction is outstanding.
REQ-029 A load that follows a store to the same address SHALL return the stored data.

Reset
REQ-030 While reset=0 at an edge, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-031 After reset, req_ready SHALL be 1 and rsp_valid, rsp_rdata and rsp_err SHALL be 0.
REQ-032 Reset during WAIT SHALL drop the pending transaction with no array write.
REQ-033 Reset during RESP SHALL discard the response.
REQ-034 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-035 With the macro DMEM_STATS_EN defined, the block SHALL add two outputs, rd_count and wr_count, each 16 bits.
REQ-036 With DMEM_STATS_EN defined, rd_count/wr_count SHALL increment by one at each non-error load/store entry to RESP.
REQ-037 With DMEM_STATS_EN defined, rd_count and wr_count SHALL saturate at 16'hFFFF and clear on reset.
REQ-038 With DMEM_STATS_EN undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 Store then load, WAIT_CYCLES=2: store 0xDEADBEEF at 0x10, then load 0x10 -> rsp_valid 3 cycles after each accept; load returns rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-040 WAIT_CYCLES=0: load accepted at edge T -> rsp_valid=1 in the cycle after T; req_ready=0 in that cycle.
REQ-041 Misaligned and out-of-range accesses: store to 0x12 -> rsp_err=1; a later load of 0x10 still returns the prior value. Load of 4*DEPTH -> rsp_err=1, rsp_rdata=0.
REQ-042 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable; req_valid pulses during that time ignored.
REQ-043 Reset mid-operation: accept store 0x12345678 at 0x20, assert reset in WAIT -> IDLE, req_ready=1; a later load of 0x20 returns the old value.
REQ-044 DMEM_STATS_EN defined, 3 loads + 2 stores + 1 error -> rd_count=3, wr_count=2; reset -> both 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for an MA stage.
//
// A request is taken in IDLE, held through WAIT_CYCLES wait states, and then
// answered from RESP until the initiator takes the response. Stores write the
// word array and loads read it on the edge that enters RESP. Accesses that are
// misaligned or fall past the array are answered with rsp_err=1 and no effect.
//
// Parameters
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//   DEPTH        number of 32-bit words in the backing array
//
// Ports
//   clk, reset                      clock; synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_wdata     request payload (store flag, byte address, store data)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              response payload
//   rd_count, wr_count              access statistics (only with DMEM_STATS_EN)
//   dbg_state                       current FSM state, for observation
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1.
// Once rsp_valid is raised its payload holds until that transfer; the request
// side is ready only while idle, so at most one transaction is in flight.
//
// Optional feature: define DMEM_STATS_EN to add the rd_count/wr_count outputs.

module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
`ifdef DMEM_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  output logic [1:0]  dbg_state
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
`endif

  // The access performed on entry to RESP. With zero wait states entry
  // coincides with acceptance, so the live request inputs are used then;
  // otherwise the captured copy is used.
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          enter_resp;
  logic          mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef DMEM_STATS_EN
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
`endif
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    acc_we    = (state_q == IDLE) ? req_we    : we_q;
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH_W);
    acc_idx   = acc_addr[AW+1:2];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      state_d = RESP;
      err_d   = acc_err;
      rdata_d = (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
      mem_we  = acc_we && !acc_err;
`ifdef DMEM_STATS_EN
      if (!acc_err && !acc_we && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
      if (!acc_err &&  acc_we && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
`ifdef DMEM_STATS_EN
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef DMEM_STATS_EN
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
`endif
    end
  end

  // The array keeps its contents across reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;
`ifdef DMEM_STATS_EN
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a transaction-level reference model tracks
// what each output must be from the accept time, wait-state count and a plain
// word array; a negedge process compares every cycle. Directed sequences add
// literal expectations. A second instance with zero wait states covers the
// single-cycle path.

module tb_dmem_responder;

  localparam int WC  = 2;
  localparam int DEP = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  logic        z_reset = 1'b0;
  logic        z_req_valid = 1'b0;
  logic        z_req_we = 1'b0;
  logic [31:0] z_req_addr = 32'd0;
  logic [31:0] z_req_wdata = 32'd0;
  logic        z_rsp_ready = 1'b0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  logic [1:0]  z_dbg_state;
`ifdef DMEM_STATS_EN
  logic [15:0] z_rd_count, z_wr_count;
`endif

  dmem_responder #(.WAIT_CYCLES(WC), .DEPTH(DEP)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef DMEM_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count),
`endif
    .dbg_state(dbg_state)
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH(DEP)) u_dut0 (
    .clk(clk), .reset(z_reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
`ifdef DMEM_STATS_EN
    .rd_count(z_rd_count), .wr_count(z_wr_count),
`endif
    .dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a request seen while not busy is accepted; its response
  // appears after edge (accept edge + WC) and stays until rsp_ready is seen.
  int unsigned n_edge = 0;
  int unsigned m_due  = 0;
  bit          m_busy = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_we   = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] m_mem [DEP];
  logic [15:0] m_rd = 16'd0;
  logic [15:0] m_wr = 16'd0;
  logic [31:0] exp_q [$];   // load results expected at the directed level

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEP));
  endfunction

  task automatic m_enter();
    m_resp = 1'b1;
    m_err  = addr_bad(m_addr);
    m_rdata = 32'd0;
    if (!m_err) begin
      if (m_we) begin
        m_mem[m_addr >> 2] = m_wdata;
        if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
      end else begin
        m_rdata = m_mem[m_addr >> 2];
        if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
      end
    end
  endtask

  always @(posedge clk) begin
    n_edge++;
    if (!reset) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
      m_rd   = 16'd0;
      m_wr   = 16'd0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1'b1;
        m_we    = req_we;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_due   = n_edge + WC;
        if (WC == 0) m_enter();
      end
    end else if (!m_resp) begin
      if (n_edge == m_due) m_enter();
    end else if (rsp_ready) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("rsp_rdata", rsp_rdata, m_resp ? m_rdata : 32'd0);
      chk("rsp_err",   32'(rsp_err), 32'(m_resp && m_err));
`ifdef DMEM_STATS_EN
      chk("rd_count", 32'(rd_count), 32'(m_rd));
      chk("wr_count", 32'(wr_count), 32'(m_wr));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge with the main DUT idle; returns just after a
  // negedge with the DUT idle again. While waiting, the req_* inputs and
  // rsp_ready are scrambled to show they are ignored.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, output logic [31:0] rd, output logic err, output int lat);
    bit got;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        #1;
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, expected within %0d", lat, WC + 1);
    end
    rd  = rsp_rdata;
    err = rsp_err;
    #1;
    rsp_ready = 1'b0;
    repeat (hold) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err",   32'(rsp_err), 32'(err));
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- main stimulus ----------------
  logic [31:0] rd;
  logic        err;
  int          lat;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    reset   = 1'b1;
    z_reset = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err",   32'(rsp_err), 32'd0);
    #1;

    // Give every word a known value.
    for (int i = 0; i < DEP; i++) txn(1'b1, 32'(i * 4), $urandom, 0, rd, err, lat);

    // Store then load.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, err, lat);
    chk("st_latency", 32'(lat), 32'd3);
    chk("st_err", 32'(err), 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0, 5, rd, err, lat);   // with 5 cycles of backpressure
    chk("ld_latency", 32'(lat), 32'd3);
    chk("ld_rdata", rd, exp_q.pop_front());
    chk("ld_err", 32'(err), 32'd0);

    // Misaligned store is rejected and leaves the word alone.
    txn(1'b1, 32'h12, 32'h55555555, 0, rd, err, lat);
    chk("mis_err", 32'(err), 32'd1);
    txn(1'b0, 32'h10, 32'h0, 0, rd, err, lat);
    chk("mis_keep", rd, 32'hDEADBEEF);

    // Out-of-range load.
    txn(1'b0, 32'(4 * DEP), 32'h0, 1, rd, err, lat);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_rdata", rd, 32'd0);

    // Reset during WAIT drops a pending store.
    txn(1'b1, 32'h20, 32'hA5A50020, 0, rd, err, lat);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", 32'(req_ready), 32'd1);
    chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
    #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    txn(1'b0, 32'h20, 32'h0, 0, rd, err, lat);
    chk("rst_old_value", rd, 32'hA5A50020);

`ifdef DMEM_STATS_EN
    pulse_reset();
    txn(1'b0, 32'h0, 32'h0, 0, rd, err, lat);
    txn(1'b1, 32'h4, 32'h1, 0, rd, err, lat);
    txn(1'b0, 32'h8, 32'h0, 0, rd, err, lat);
    txn(1'b0, 32'h3, 32'h0, 0, rd, err, lat);
    txn(1'b1, 32'hC, 32'h2, 0, rd, err, lat);
    txn(1'b0, 32'h4, 32'h0, 0, rd, err, lat);
    chk("stats_rd", 32'(rd_count), 32'd3);
    chk("stats_wr", 32'(wr_count), 32'd2);
    pulse_reset();
    @(negedge clk);
    chk("stats_rd_clr", 32'(rd_count), 32'd0);
    chk("stats_wr_clr", 32'(wr_count), 32'd0);
    #1;
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 150; i++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'($urandom_range(0, DEP - 1) * 4);
      else if (sel == 8) a = 32'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
      else               a = 32'((DEP + $urandom_range(0, 100)) * 4);
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, err, lat);
    end

    // Zero-wait-state instance: response in the cycle right after acceptance.
    z_req_valid = 1'b1;
    z_req_we    = 1'b1;
    z_req_addr  = 32'h8;
    z_req_wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    chk("z_st_valid", 32'(z_rsp_valid), 32'd1);
    chk("z_st_ready", 32'(z_req_ready), 32'd0);
    chk("z_st_err",   32'(z_rsp_err), 32'd0);
    chk("z_st_rdata", z_rsp_rdata, 32'd0);
    #1;
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b1;
    @(negedge clk);
    chk("z_idle_valid", 32'(z_rsp_valid), 32'd0);
    chk("z_idle_ready", 32'(z_req_ready), 32'd1);
    #1;
    z_rsp_ready = 1'b0;
    z_req_valid = 1'b1;
    z_req_we    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("z_ld_valid", 32'(z_rsp_valid), 32'd1);
    chk("z_ld_ready", 32'(z_req_ready), 32'd0);
    chk("z_ld_rdata", z_rsp_rdata, 32'h0BADF00D);
    #1;
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    z_rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
